// File: rtl/rsa_modexp_engine.sv
// Sequential modular exponentiation (base^exp mod n) with a leaky square-and-multiply
// mode and a constant-time Montgomery-ladder mode, sharing one bit-serial modular multiplier.
module rsa_modexp_engine #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned EXP_WIDTH = 16,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exp,
  input  logic [WIDTH-1:0]     n,
  output logic [WIDTH-1:0]     result,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] cycles
);

  localparam int unsigned MCW = $clog2(WIDTH + 1);
  localparam int unsigned ECW = $clog2(EXP_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_REDUCE, S_SQ, S_MUL, S_LAD_A, S_LAD_B, S_FINISH
  } state_t;

  state_t               state_q;
  logic                 mode_q, bad_q;
  logic [WIDTH-1:0]     base_q, n_q, bval_q, r0_q, r1_q;
  logic [EXP_WIDTH-1:0] e_q;
  logic [ECW-1:0]       bcnt_q;
  logic [WIDTH-1:0]     ma_q, mb_q;
  logic [WIDTH+1:0]     acc_q;
  logic [MCW-1:0]       mcnt_q;
  logic [WIDTH-1:0]     result_q;
  logic                 busy_q, done_q, err_q;
  logic [CNT_WIDTH-1:0] cycles_q;

  logic [WIDTH+1:0]     nx, bx, dbl, red1, sum, step_full;
  logic [WIDTH-1:0]     step_r, lad_r0n, lad_r1n;
  logic                 mul_last, exp_bit, last_bit, in_mul;

  // One interleaved step: r = 2r mod n, then r = (r + a[i]*b) mod n; r < n keeps WIDTH+2 bits safe.
  always_comb begin
    nx        = {2'b00, n_q};
    bx        = {2'b00, mb_q};
    dbl       = {acc_q[WIDTH:0], 1'b0};
    red1      = (dbl >= nx) ? dbl - nx : dbl;
    sum       = red1 + (ma_q[WIDTH-1] ? bx : '0);
    step_full = (sum >= nx) ? sum - nx : sum;
    step_r    = step_full[WIDTH-1:0];
    mul_last  = (mcnt_q == MCW'(WIDTH - 1));
    exp_bit   = e_q[EXP_WIDTH-1];
    last_bit  = (bcnt_q == '0);
    in_mul    = (state_q == S_REDUCE) || (state_q == S_SQ) || (state_q == S_MUL) ||
                (state_q == S_LAD_A) || (state_q == S_LAD_B);
    lad_r0n   = exp_bit ? r0_q : step_r;
    lad_r1n   = exp_bit ? step_r : r1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      bad_q    <= 1'b0;
      base_q   <= '0;
      n_q      <= '0;
      bval_q   <= '0;
      r0_q     <= '0;
      r1_q     <= '0;
      e_q      <= '0;
      bcnt_q   <= '0;
      ma_q     <= '0;
      mb_q     <= '0;
      acc_q    <= '0;
      mcnt_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cycles_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE && cycles_q != '1)
        cycles_q <= cycles_q + 1'b1;

      // Multiplier sequencing; each state below only loads the next operands on mul_last.
      if (in_mul) begin
        if (mul_last) begin
          acc_q  <= '0;
          mcnt_q <= '0;
        end else begin
          acc_q  <= step_full;
          mcnt_q <= mcnt_q + 1'b1;
          ma_q   <= ma_q << 1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q   <= mode;
            base_q   <= base;
            e_q      <= exp;
            n_q      <= n;
            busy_q   <= 1'b1;
            err_q    <= 1'b0;
            cycles_q <= '0;
            state_q  <= S_LOAD;
          end
        end
        S_LOAD: begin
          acc_q  <= '0;
          mcnt_q <= '0;
          bcnt_q <= ECW'(EXP_WIDTH - 1);
          if (n_q < WIDTH'(2)) begin
            bad_q   <= 1'b1;
            state_q <= S_FINISH;
          end else begin
            bad_q   <= 1'b0;
            ma_q    <= base_q;
            mb_q    <= WIDTH'(1);
            state_q <= S_REDUCE;
          end
        end
        S_REDUCE: begin
          if (mul_last) begin
            bval_q <= step_r;
            r0_q   <= WIDTH'(1);
            r1_q   <= step_r;
            ma_q   <= WIDTH'(1);
            if (mode_q) begin
              mb_q    <= step_r;
              state_q <= S_LAD_A;
            end else begin
              mb_q    <= WIDTH'(1);
              state_q <= S_SQ;
            end
          end
        end
        S_SQ, S_MUL: begin
          if (mul_last) begin
            r0_q <= step_r;
            if (state_q == S_SQ && exp_bit) begin
              ma_q    <= step_r;
              mb_q    <= bval_q;
              state_q <= S_MUL;
            end else if (last_bit) begin
              state_q <= S_FINISH;
            end else begin
              e_q     <= e_q << 1;
              bcnt_q  <= bcnt_q - 1'b1;
              ma_q    <= step_r;
              mb_q    <= step_r;
              state_q <= S_SQ;
            end
          end
        end
        S_LAD_A: begin
          if (mul_last) begin
            if (exp_bit) begin
              r0_q <= step_r;
              ma_q <= r1_q;
              mb_q <= r1_q;
            end else begin
              r1_q <= step_r;
              ma_q <= r0_q;
              mb_q <= r0_q;
            end
            state_q <= S_LAD_B;
          end
        end
        S_LAD_B: begin
          if (mul_last) begin
            r0_q <= lad_r0n;
            r1_q <= lad_r1n;
            if (last_bit) begin
              state_q <= S_FINISH;
            end else begin
              e_q     <= e_q << 1;
              bcnt_q  <= bcnt_q - 1'b1;
              ma_q    <= lad_r0n;
              mb_q    <= lad_r1n;
              state_q <= S_LAD_A;
            end
          end
        end
        S_FINISH: begin
          result_q <= bad_q ? '0 : r0_q;
          err_q    <= bad_q;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign cycles = cycles_q;

endmodule
